hamming_tx_encoder: RTL and testbench
=====================================

# hamming_tx_encoder

Buffered Hamming(7,4) encoder stage that feeds `Hamming_code_decoder`. It accepts 4-bit data words over a valid/ready handshake and queues them in a small FIFO. It encodes each word into a 7-bit codeword with selectable even/odd parity, and can optionally flip one codeword bit to exercise the downstream corrector. Codewords are presented on a registered valid/ready output whose `x` and `out_select` connect directly to the decoder's `x` and `select`.

## Interface
- `FIFO_DEPTH`, default 4: input FIFO entries; power of two, ≥2.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: upstream word valid.
- `in_ready`  out  1: FIFO not full; a word transfers when `in_valid & in_ready` at a rising edge.
- `in_data`  in  4: data nibble; d1=`in_data[3]`, d2=[2], d3=[1], d4=[0].
- `in_select`  in  1: parity mode for this word, 0=even, 1=odd; stored with the word.
- `inj_en`  in  1: error-injection enable, sampled when the output register loads.
- `inj_pos`  in  3: codeword position to flip, 1..7; 0 means no flip.
- `out_valid`  out  1: codeword valid.
- `out_ready`  in  1: downstream accepts; a codeword transfers when `out_valid & out_ready` at a rising edge.
- `x`  out  7: codeword; `x[6]`=pos1 … `x[0]`=pos7.
- `out_select`  out  1: parity mode of the current codeword.
- `word_cnt`  out  8: count of completed output transfers; wraps 255→0.

## Operation
- **FIFO.**
  - Holds {select, data} entries (5 bits each).
  - Write on an input handshake; read when the output register loads.
  - `in_ready = !full`, using the full flag from the start of the cycle. A pop in the same cycle does not make room for a push in that cycle.
  - No bypass: a word written into an empty FIFO becomes readable on the next cycle.
- **Encoding.**
  - Position order: pos1..7 = p1 p2 d1 p4 d2 d3 d4.
  - Even parity: p1 = d1^d2^d4, p2 = d1^d3^d4, p4 = d2^d3^d4.
  - Odd parity (select=1): each of p1, p2, p4 is inverted; data bits are unchanged.
- **Injection.**
  - If `inj_en=1` and `inj_pos` is in 1..7, bit `x[7-inj_pos]` is inverted in the loaded codeword.
  - Injection is evaluated only at load time. Changes to `inj_en`/`inj_pos` while `out_valid` is high do not alter a held codeword.
- **Output register.**
  - Loads when the FIFO is non-empty and either `out_valid=0` or an output handshake occurs in the same cycle. This gives full throughput of one word per cycle.
  - While `out_valid=1` and `out_ready=0`, `x` and `out_select` hold stable.
  - `out_valid` drops after a handshake when the FIFO is empty.
- **Counter.** `word_cnt` increments by 1 on each output handshake, modulo 256.
- **Reset** (async assert, sync-released internally to `clk` edges):
  - FIFO pointers are cleared and contents discarded.
  - `out_valid=0`, `x=0`, `out_select=0`, `word_cnt=0`, `in_ready=1`.
  - Reset mid-transfer drops all queued and presented words with no partial output.

## Timing
- Latency: a word accepted at edge t appears with `out_valid=1` after edge t+1, provided the output register is free. This is 2 cycles from `in_valid` to `out_valid`.
- Sustained throughput is 1 word/cycle with `out_ready` held high.
- With `out_ready=0`, the FIFO accepts exactly `FIFO_DEPTH` further words and then `in_ready` falls. Total words stored = `FIFO_DEPTH`+1 (including the output register).
- `in_ready` rises the cycle after the first pop from a full FIFO.
- All outputs are registered except `in_ready`, which is decoded from registered pointers.

## Test plan
- Reset, then push `in_data`=4'b1011, `in_select`=0, `inj_en`=0 → `out_valid` two cycles later with `x`=7'b0110011, `out_select`=0; after the handshake, `word_cnt`=1.
- Push 4'b1011 with select=1 → `x`=7'b1011011; push 4'b0000 with select=1 → `x`=7'b1101000; push 4'b0000 with select=0 → `x`=7'b0000000.
- Push 4'b1011, select=0, `inj_en`=1, `inj_pos`=3 → `x`=7'b0100011. With `inj_pos`=0 → `x`=7'b0110011 unchanged.
- Hold `out_ready`=0 and stream words 0..9 → exactly 5 accepted (4 FIFO + 1 output) before `in_ready`=0. Release `out_ready` → words emerge in order 0,1,2,3,4 with no loss or duplication.
- Back-to-back 300 words with `out_ready`=1 → one output per cycle after the first; `word_cnt` wraps to 44.
- Assert `rst_n`=0 while 3 words are queued and `out_valid`=1 → outputs immediately read `out_valid=0`, `x=0`, `word_cnt=0`; after release, no stale words appear.

Source files
------------

// File: rtl/hamming_tx_encoder_if.sv
// Bus interface for hamming_tx_encoder.
//   Upstream side : in_valid/in_ready/in_data/in_select plus the error
//                   injection controls inj_en/inj_pos.
//   Downstream side: out_valid/out_ready/x/out_select and the word_cnt status.
// Handshake rule, on both sides: a transfer happens on a rising clk edge where
// valid and ready are both high. A source holds valid and its payload stable
// until that edge. Ready may change freely and never depends on valid.
// Modports: master = the agent that feeds words and accepts codewords,
//           slave  = the encoder itself.
interface hamming_tx_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_select;
  logic       inj_en;
  logic [2:0] inj_pos;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] x;
  logic       out_select;
  logic [7:0] word_cnt;

  modport master (
    output in_valid, in_data, in_select, inj_en, inj_pos, out_ready,
    input  in_ready, out_valid, x, out_select, word_cnt
  );

  modport slave (
    input  in_valid, in_data, in_select, inj_en, inj_pos, out_ready,
    output in_ready, out_valid, x, out_select, word_cnt
  );
endinterface

// File: rtl/hamming_tx_encoder.sv
// Buffered Hamming(7,4) encoder feeding Hamming_code_decoder.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset (released synchronously inside)
//   bus   - hamming_tx_encoder_if.slave carrying the input handshake, the
//           error-injection controls, the registered codeword output and
//           the word_cnt transfer counter.
// Words enter a FIFO_DEPTH-entry FIFO of {select, data}. The head entry is
// encoded combinationally and captured, with an optional single-bit flip,
// in the output register whenever that register is empty or is being
// drained in the same cycle.
module hamming_tx_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  hamming_tx_encoder_if.slave bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Reset synchroniser: assertion reaches every flop immediately, release
  // is aligned to clk through two stages.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];

  // FIFO storage with one extra pointer bit to tell full from empty.
  logic [4:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Output register state.
  logic       out_valid_q;
  logic [6:0] x_q;
  logic       out_select_q;
  logic [7:0] word_cnt_q;
  logic       out_fire;
  logic       load;

  assign out_fire = out_valid_q && bus.out_ready;
  // Refill whenever the register is free now or is being emptied this cycle.
  assign load     = !empty && (!out_valid_q || bus.out_ready);
  // in_ready uses only the start-of-cycle full flag, so a same-cycle pop
  // never opens a slot for a same-cycle push.
  assign push     = bus.in_valid && !full;
  assign pop      = load;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {bus.in_select, bus.in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Encoder on the FIFO head.
  logic [4:0] head;
  logic       head_sel;
  logic       d1, d2, d3, d4;
  logic       p1, p2, p4;
  logic [6:0] code;

  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_sel = head[4];
  assign d1       = head[3];
  assign d2       = head[2];
  assign d3       = head[1];
  assign d4       = head[0];

  // Odd parity is even parity with every check bit inverted.
  assign p1   = d1 ^ d2 ^ d4 ^ head_sel;
  assign p2   = d1 ^ d3 ^ d4 ^ head_sel;
  assign p4   = d2 ^ d3 ^ d4 ^ head_sel;
  assign code = {p1, p2, d1, p4, d2, d3, d4};

  // Position n (1..7) lives at x[7-n]; position 0 means no flip.
  logic [6:0] inj_mask;

  always_comb begin
    inj_mask = 7'b0000000;
    if (bus.inj_en) begin
      case (bus.inj_pos)
        3'd1:    inj_mask = 7'b1000000;
        3'd2:    inj_mask = 7'b0100000;
        3'd3:    inj_mask = 7'b0010000;
        3'd4:    inj_mask = 7'b0001000;
        3'd5:    inj_mask = 7'b0000100;
        3'd6:    inj_mask = 7'b0000010;
        3'd7:    inj_mask = 7'b0000001;
        default: inj_mask = 7'b0000000;
      endcase
    end
  end

  // Output register: injection controls only matter at load, so a held
  // codeword is immune to later changes on inj_en/inj_pos.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      out_valid_q  <= 1'b0;
      x_q          <= '0;
      out_select_q <= 1'b0;
    end else if (load) begin
      out_valid_q  <= 1'b1;
      x_q          <= code ^ inj_mask;
      out_select_q <= head_sel;
    end else if (out_fire) begin
      out_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      word_cnt_q <= '0;
    end else if (out_fire) begin
      word_cnt_q <= word_cnt_q + 8'd1;
    end
  end

  assign bus.in_ready   = !full;
  assign bus.out_valid  = out_valid_q;
  assign bus.x          = x_q;
  assign bus.out_select = out_select_q;
  assign bus.word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_hamming_tx_encoder.sv
// Directed testbench for hamming_tx_encoder (FIFO_DEPTH = 4).
module tb_hamming_tx_encoder;

  logic clk;
  logic rst_n;

  hamming_tx_encoder_if bus ();

  hamming_tx_encoder #(.FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  logic [6:0] exp_q [$];

  // Reference encoder written straight from the parity equations.
  function automatic logic [6:0] enc(input logic [3:0] d, input logic s);
    logic a, b, c, e;
    a = d[3]; b = d[2]; c = d[1]; e = d[0];
    return {a ^ b ^ e ^ s, a ^ c ^ e ^ s, a, b ^ c ^ e ^ s, b, c, e};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: cross the active edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: offer one word and return after the edge that transfers it.
  task automatic push(input logic [3:0] d, input logic s);
    bit done;
    done = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_select = s;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.in_ready) done = 1;
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) check("push_timeout", 32'd1, 32'd0);
  endtask

  // Wait (bounded) for out_valid.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    check(tag, 32'(bus.out_valid), 32'd1);
  endtask

  // Accept the presented codeword and check the counter afterwards.
  task automatic drain_one();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    check("word_cnt", 32'(bus.word_cnt), 32'(exp_cnt));
  endtask

  typedef struct {
    logic [3:0] d;
    logic       s;
    logic       ie;
    logic [2:0] ip;
    logic [6:0] xe;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int acc_cnt, nxt, sent, got, gaps;
    bit started, acc;
    logic [6:0] held;

    vecs[0] = '{4'b1011, 1'b1, 1'b0, 3'd0, 7'b1011011};
    vecs[1] = '{4'b0000, 1'b1, 1'b0, 3'd0, 7'b1101000};
    vecs[2] = '{4'b0000, 1'b0, 1'b0, 3'd0, 7'b0000000};
    vecs[3] = '{4'b1011, 1'b0, 1'b1, 3'd3, 7'b0100011};
    vecs[4] = '{4'b1011, 1'b0, 1'b1, 3'd0, 7'b0110011};
    vecs[5] = '{4'b1011, 1'b0, 1'b1, 3'd7, 7'b0110010};
    vecs[6] = '{4'b0000, 1'b0, 1'b1, 3'd1, 7'b1000000};
    vecs[7] = '{4'b0110, 1'b0, 1'b0, 3'd0, 7'b1100110};
    vecs[8] = '{4'b0110, 1'b1, 1'b0, 3'd0, 7'b0001110};

    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.in_select = 1'b0;
    bus.inj_en    = 1'b0;
    bus.inj_pos   = 3'd0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_x", 32'(bus.x), 32'd0);
    check("rst_out_select", 32'(bus.out_select), 32'd0);
    check("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // First word: two-cycle latency, even parity
    push(4'b1011, 1'b0);
    check("lat_not_yet", 32'(bus.out_valid), 32'd0);
    step();
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    check("first_x", 32'(bus.x), 32'b0110011);
    check("first_sel", 32'(bus.out_select), 32'd0);
    drain_one();
    check("first_drop", 32'(bus.out_valid), 32'd0);

    // Parity modes and injection, plus hold-stability under inj changes
    for (int v = 0; v < 9; v++) begin
      bus.inj_en  = vecs[v].ie;
      bus.inj_pos = vecs[v].ip;
      push(vecs[v].d, vecs[v].s);
      wait_valid($sformatf("vec%0d_valid", v));
      check($sformatf("vec%0d_x", v), 32'(bus.x), 32'(vecs[v].xe));
      check($sformatf("vec%0d_sel", v), 32'(bus.out_select), 32'(vecs[v].s));
      held = vecs[v].xe;
      bus.inj_en  = 1'b1;
      bus.inj_pos = 3'($urandom_range(1, 7));
      step();
      bus.inj_en  = ~vecs[v].ie;
      bus.inj_pos = 3'($urandom_range(1, 7));
      step();
      check($sformatf("vec%0d_hold", v), 32'(bus.x), 32'(held));
      bus.inj_en  = 1'b0;
      bus.inj_pos = 3'd0;
      drain_one();
    end

    // Backpressure: stream 0..9 with out_ready low
    acc_cnt = 0;
    nxt = 0;
    for (int c = 0; c < 14; c++) begin
      bus.in_valid  = (nxt < 10);
      bus.in_data   = nxt[3:0];
      bus.in_select = 1'b0;
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) begin
        acc_cnt++;
        nxt++;
      end
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", 32'(acc_cnt), 32'd5);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid%0d", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_x%0d", k), 32'(bus.x), 32'(enc(4'(k), 1'b0)));
      step();
      exp_cnt = (exp_cnt + 1) % 256;
      if (k == 0) check("bp_in_ready_rise", 32'(bus.in_ready), 32'd1);
    end
    bus.out_ready = 1'b0;
    check("bp_empty", 32'(bus.out_valid), 32'd0);
    check("bp_word_cnt", 32'(bus.word_cnt), 32'(exp_cnt));

    // Reset with 3 queued words and one presented
    for (int k = 1; k <= 4; k++) push(4'(k), 1'b1);
    check("rq_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rq_out_valid", 32'(bus.out_valid), 32'd0);
    check("rq_x", 32'(bus.x), 32'd0);
    check("rq_word_cnt", 32'(bus.word_cnt), 32'd0);
    check("rq_out_select", 32'(bus.out_select), 32'd0);
    check("rq_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rq_stale%0d", k), 32'(bus.out_valid), 32'd0);
      step();
    end

    // 300 back-to-back words with out_ready high
    sent = 0;
    got = 0;
    gaps = 0;
    started = 0;
    for (int c = 0; c < 400 && got < 300; c++) begin
      if (sent < 300) begin
        bus.in_valid  = 1'b1;
        bus.in_data   = sent[3:0];
        bus.in_select = sent[4];
      end else begin
        bus.in_valid = 1'b0;
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) exp_q.push_back(enc(sent[3:0], sent[4]));
      if (bus.out_valid) begin
        started = 1;
        got++;
        if (exp_q.size() == 0) check("stream_extra", 32'd1, 32'd0);
        else check("stream_x", 32'(bus.x), 32'(exp_q.pop_front()));
      end else if (started) begin
        gaps++;
      end
      step();
      if (acc) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("stream_count", 32'(got), 32'd300);
    check("stream_gaps", 32'(gaps), 32'd0);
    check("stream_wrap", 32'(bus.word_cnt), 32'd44);
    check("stream_idle", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
